// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// data-memory wait stalls, with a wait watchdog and performance counters.
module hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_D,
  input  logic [4:0]       rs2_D,
  input  logic             rs1_used_D,
  input  logic             rs2_used_D,
  input  logic             mem_readE,
  input  logic [4:0]       rd_E,
  input  logic             branch_takenE,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             hazard,
  output logic             hazard_ld,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;
  logic              mem_stall;
  logic              load_use;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              branch_flush;

  assign wait_next = wait_cnt + WAIT_ONE;

  // A load into x0 never produces a value worth waiting for.
  assign rs1_hit  = rs1_used_D && (rs1_D == rd_E);
  assign rs2_hit  = rs2_used_D && (rs2_D == rd_E);
  assign load_use = mem_readE && (rd_E != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    mem_stall = 1'b0;
    case (state)
      RUN:      mem_stall = mem_req_M && !mem_ready_M;
      MEM_WAIT: mem_stall = !mem_ready_M;
      TIMEOUT:  mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  // Memory stall freezes everything; a held branch or load-use resolves later.
  always_comb begin
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    hazard        = 1'b0;
    hazard_ld     = 1'b0;
    ex_mem_hold   = 1'b0;
    mem_wb_bubble = 1'b0;
    branch_flush  = 1'b0;
    if (mem_stall) begin
      pc_hold       = 1'b1;
      if_id_hold    = 1'b1;
      hazard_ld     = 1'b1;
      ex_mem_hold   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (branch_takenE) begin
      if_id_flush  = 1'b1;
      hazard       = 1'b1;
      branch_flush = 1'b1;
    end else if (load_use) begin
      pc_hold    = 1'b1;
      if_id_hold = 1'b1;
      hazard     = 1'b1;
    end
  end

  // Watchdog: wait_cnt counts consecutive unanswered memory cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_req_M && !mem_ready_M) begin
            wait_cnt <= WAIT_ONE;
            if (WAIT_ONE == WAIT_LIMIT) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ready_M) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_next;
            if (wait_next == WAIT_LIMIT) begin
              state       <= TIMEOUT;
              mem_timeout <= 1'b1;
            end
          end
        end
        TIMEOUT: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_hold)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (branch_flush)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller. It is the producer of the stall/flush controls consumed by the IF/ID and ID/EX pipeline registers: `hazard` flushes ID/EX and `hazard_ld` holds it. It detects load-use hazards, taken-branch redirects and multi-cycle data-memory waits, and sequences the matching bubbles, holds and flushes. It also keeps a memory-wait watchdog and performance counters.

Parameters:
- MAX_WAIT, 16: maximum consecutive data-memory wait cycles before timeout (≥1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rs1_D  in  5  rs1 address of instruction in ID
- rs2_D  in  5  rs2 address of instruction in ID
- rs1_used_D  in  1  ID instruction reads rs1
- rs2_used_D  in  1  ID instruction reads rs2
- mem_readE  in  1  EX instruction is a load
- rd_E  in  5  EX destination register
- branch_takenE  in  1  EX branch/jump resolved taken
- mem_req_M  in  1  MEM stage issuing a data-memory access
- mem_ready_M  in  1  data memory completes the access this cycle
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF/ID keeps its contents
- if_id_flush  out  1  IF/ID loads a NOP
- hazard  out  1  ID/EX flush (bubble)
- hazard_ld  out  1  ID/EX hold
- ex_mem_hold  out  1  EX/MEM hold
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  count of cycles with pc_hold=1
- flush_count  out  CNT_W  count of branch flushes issued

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT. Reset (synchronous) → RUN, wait_cnt=0, mem_timeout=0, both counters=0.
- Control outputs are combinational from state and inputs (same-cycle effect). Counters and mem_timeout are registered.
- mem_stall = (state==RUN && mem_req_M && !mem_ready_M) || (state==MEM_WAIT && !mem_ready_M) || state==TIMEOUT.
- Load-use: lu = mem_readE && rd_E!=0 && ((rs1_used_D && rs1_D==rd_E) || (rs2_used_D && rs2_D==rd_E)).
- Priority: mem_stall > branch_takenE > lu.
- mem_stall active:
  - pc_hold, if_id_hold, hazard_ld, ex_mem_hold, mem_wb_bubble = 1.
  - hazard = 0, if_id_flush = 0.
  - branch_takenE and lu are ignored. They remain held in EX and take effect once the stall releases.
- Else if branch_takenE:
  - if_id_flush = 1, hazard = 1; pc_hold = 0 (PC takes the target).
  - flush_count increments.
- Else if lu: pc_hold = 1, if_id_hold = 1, hazard = 1 (exactly one bubble). The next cycle has the load in MEM, so lu is false.
- Otherwise all control outputs = 0.
- Transitions:
  - RUN → MEM_WAIT when mem_req_M && !mem_ready_M; wait_cnt ← 1.
  - MEM_WAIT → RUN on mem_ready_M. The stall drops in that same cycle; wait_cnt ← 0.
  - MEM_WAIT with !mem_ready_M: wait_cnt++. When wait_cnt==MAX_WAIT → TIMEOUT, mem_timeout ← 1.
  - TIMEOUT: pipeline fully stalled and mem_timeout held until rst; mem_ready_M is ignored.
- A zero-wait access (mem_req_M && mem_ready_M in RUN) produces no stall.
- stall_cycles increments every cycle pc_hold=1. Both counters wrap modulo 2^CNT_W.
- rst asserted mid-wait or in TIMEOUT: next cycle is RUN with all outputs 0 and counters cleared.
- rs1/rs2 compare against x0 never stalls (rd_E==0 is excluded).

Test Plan:
- Load-use: mem_readE=1, rd_E=5, rs1_D=5, rs1_used_D=1 for 1 cycle → pc_hold=if_id_hold=hazard=1 that cycle, hazard_ld=0; stall_cycles=1 afterwards.
- x0 / unused operand: rd_E=0 with rs1_D=0, then rd_E=7 with rs2_D=7 and rs2_used_D=0 → no stall in either case.
- Branch: branch_takenE=1 with lu also true → if_id_flush=hazard=1, pc_hold=0; flush_count=1.
- Memory wait: mem_req_M=1, mem_ready_M low for 3 cycles then high → 3 cycles with hazard_ld=ex_mem_hold=mem_wb_bubble=pc_hold=1, released in the ready cycle; stall_cycles=3.
- Branch during wait: branch_takenE=1 throughout a 2-cycle wait → no flush while stalled; flush asserted in the ready cycle; flush_count=1.
- Timeout: MAX_WAIT=4, ready never asserted → mem_timeout=1 after 4 wait cycles; stall persists; rst clears everything and state returns to RUN.
